// File: rtl/phase_sequencer_pkg.sv
// Shared types and defaults for the phase sequencer.
package phase_sequencer_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        STEP    = 2'd2,
        HALTED  = 2'd3
    } seq_state_t;

    localparam int INSTR_COUNT_W = 16;

    localparam int DEF_NUM_PHASES      = 5;
    localparam int DEF_PHASE_CYCLES    = 2;
    localparam int DEF_PHASE_HIGH      = 1;
    localparam int DEF_DEBOUNCE_CYCLES = 255;

endpackage

// File: rtl/button_debouncer.sv
// Debounces one raw button: the level flips after DEBOUNCE_CYCLES consecutive
// differing samples; press is high on the sample that makes the level rise.
module button_debouncer
    import phase_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             flip;

    assign flip  = (raw != level) && (count == CNT_LAST);
    assign press = flip && raw;

    always_ff @(posedge clock) begin
        if (reset) begin
            level <= 1'b0;
            count <= '0;
        end else if (raw == level) begin
            count <= '0;
        end else if (flip) begin
            level <= raw;
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase clock sequencer: free-run, single-step and halt, stopping only at
// instruction boundaries. Define PHASESEQ_LIMIT_EN to add the instr_limit input.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int NUM_PHASES      = DEF_NUM_PHASES,
    parameter int PHASE_CYCLES    = DEF_PHASE_CYCLES,
    parameter int PHASE_HIGH      = DEF_PHASE_HIGH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          execbutton,
    input  logic                          stepbutton,
    input  logic                          haltin,
`ifdef PHASESEQ_LIMIT_EN
    input  logic [INSTR_COUNT_W-1:0]      instr_limit,
`endif
    output logic [NUM_PHASES-1:0]         phase_clk,
    output logic [$clog2(NUM_PHASES)-1:0] phase_index,
    output logic                          running,
    output logic                          halted,
    output logic [INSTR_COUNT_W-1:0]      instr_count
);

    localparam int IDX_W  = $clog2(NUM_PHASES);
    localparam int SLOT_W = $clog2(PHASE_CYCLES + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_PHASES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PHASE_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_HIGH = SLOT_W'(PHASE_HIGH);

    seq_state_t                 state, state_n;
    logic [SLOT_W-1:0]          slot, slot_n;
    logic [IDX_W-1:0]           index_n;
    logic [NUM_PHASES-1:0]      phase_clk_n;
    logic                       stop_req, stop_req_n;
    logic                       halt_req, halt_req_n;
    logic [INSTR_COUNT_W-1:0]   count_n, count_inc;
    logic                       exec_press, step_press;
    logic                       exec_level, step_level;
    logic                       levels_unused;
    logic                       limit_hit;
    logic                       halt_pending, stop_pending;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (execbutton),
        .level (exec_level),
        .press (exec_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (stepbutton),
        .level (step_level),
        .press (step_press)
    );

    assign levels_unused = exec_level ^ step_level;
    assign count_inc     = instr_count + INSTR_COUNT_W'(1);

`ifdef PHASESEQ_LIMIT_EN
    assign limit_hit = (instr_limit != '0) && (count_inc == instr_limit);
`else
    assign limit_hit = 1'b0;
`endif

    // Requests raised on the final cycle still take effect at that boundary.
    assign halt_pending = halt_req | haltin;
    assign stop_pending = stop_req | ((state == RUN) && exec_press);

    assign running = (state == RUN) || (state == STEP);
    assign halted  = (state == HALTED);

    always_comb begin
        state_n     = state;
        slot_n      = '0;
        index_n     = '0;
        stop_req_n  = stop_req;
        halt_req_n  = halt_req;
        count_n     = instr_count;
        phase_clk_n = '0;

        case (state)
            STOPPED: begin
                if (haltin)          state_n = HALTED;
                else if (exec_press) state_n = RUN;
                else if (step_press) state_n = STEP;
            end
            RUN, STEP: begin
                halt_req_n = halt_pending;
                stop_req_n = stop_pending;
                if (slot != SLOT_LAST) begin
                    slot_n  = slot + SLOT_W'(1);
                    index_n = phase_index;
                end else if (phase_index != IDX_LAST) begin
                    index_n = phase_index + IDX_W'(1);
                end else begin
                    count_n    = count_inc;
                    halt_req_n = 1'b0;
                    stop_req_n = 1'b0;
                    if (halt_pending)                       state_n = HALTED;
                    else if (stop_pending)                  state_n = STOPPED;
                    else if ((state == STEP) || limit_hit)  state_n = STOPPED;
                    else                                    state_n = RUN;
                end
            end
            HALTED: ;
            default: state_n = STOPPED;
        endcase

        // Phase enables are registered, so they are derived from next-state values.
        if (((state_n == RUN) || (state_n == STEP)) && (slot_n < SLOT_HIGH))
            phase_clk_n = NUM_PHASES'(1) << index_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= STOPPED;
            slot        <= '0;
            phase_index <= '0;
            phase_clk   <= '0;
            stop_req    <= 1'b0;
            halt_req    <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            phase_index <= index_n;
            phase_clk   <= phase_clk_n;
            stop_req    <= stop_req_n;
            halt_req    <= halt_req_n;
            instr_count <= count_n;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized bench for phase_sequencer against a cycle-position reference model.
module tb_phase_sequencer;

    localparam int NP  = 5;
    localparam int PC  = 2;
    localparam int PH  = 1;
    localparam int DEB = 4;
    localparam int IL  = NP * PC;

    localparam int M_STOP = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_HALT = 3;

    logic                   clock = 1'b0;
    logic                   reset, execbutton, stepbutton, haltin;
    logic [NP-1:0]          phase_clk;
    logic [$clog2(NP)-1:0]  phase_index;
    logic                   running, halted;
    logic [15:0]            instr_count;
    logic [15:0]            instr_limit = 16'd0;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    // Model: mode plus position (0..IL-1) within the current instruction.
    int m_mode, m_pos, m_count, m_limit;
    bit m_stop, m_halt;
    bit m_lvl[2];
    int m_run[2];

    phase_sequencer #(
        .NUM_PHASES      (NP),
        .PHASE_CYCLES    (PC),
        .PHASE_HIGH      (PH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .execbutton  (execbutton),
        .stepbutton  (stepbutton),
        .haltin      (haltin),
`ifdef PHASESEQ_LIMIT_EN
        .instr_limit (instr_limit),
`endif
        .phase_clk   (phase_clk),
        .phase_index (phase_index),
        .running     (running),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_STOP; m_pos = 0; m_count = 0;
        m_stop = 0; m_halt = 0;
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 0;
            m_run[i] = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit s, input bit h);
        bit pe, ps, hp, sp, active;
        bit raw[2];
        int exp_clk;
        reset = r; execbutton = e; stepbutton = s; haltin = h;
        raw[0] = e; raw[1] = s;
        pe = 0; ps = 0;
`ifdef PHASESEQ_LIMIT_EN
        m_limit = int'(instr_limit);
`else
        m_limit = 0;
`endif
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == m_lvl[i]) m_run[i] = 0;
                else if (m_run[i] + 1 == DEB) begin
                    if (raw[i]) begin
                        if (i == 0) pe = 1; else ps = 1;
                    end
                    m_lvl[i] = raw[i];
                    m_run[i] = 0;
                end else m_run[i]++;
            end
            case (m_mode)
                M_STOP: begin
                    if (h)       m_mode = M_HALT;
                    else if (pe) begin m_mode = M_RUN;  m_pos = 0; end
                    else if (ps) begin m_mode = M_STEP; m_pos = 0; end
                end
                M_RUN, M_STEP: begin
                    hp = m_halt || h;
                    sp = m_stop || (m_mode == M_RUN && pe);
                    if (m_pos == IL - 1) begin
                        m_count = (m_count + 1) % 65536;
                        m_pos = 0; m_stop = 0; m_halt = 0;
                        if (hp)                    m_mode = M_HALT;
                        else if (sp)               m_mode = M_STOP;
                        else if (m_mode == M_STEP) m_mode = M_STOP;
                        else if (m_limit != 0 && m_count == m_limit) m_mode = M_STOP;
                    end else begin
                        m_pos++;
                        m_halt = hp;
                        m_stop = sp;
                    end
                end
                default: ;
            endcase
        end

        @(posedge clock);
        #1;
        cyc++;
        active  = (m_mode == M_RUN) || (m_mode == M_STEP);
        exp_clk = (active && (m_pos % PC) < PH) ? (1 << (m_pos / PC)) : 0;
        check_eq("running",     32'(running),     32'(active));
        check_eq("halted",      32'(halted),      32'(m_mode == M_HALT));
        check_eq("phase_index", 32'(phase_index), active ? 32'(m_pos / PC) : 32'd0);
        check_eq("phase_clk",   32'(phase_clk),   32'(exp_clk));
        check_eq("instr_count", 32'(instr_count), 32'(m_count));
    endtask

    initial begin
        int eh, sh, halted_for;
        bit e, s, h, r;
        reset = 1'b1; execbutton = 1'b0; stepbutton = 1'b0; haltin = 1'b0;
        model_reset();
        eh = 0; sh = 0; halted_for = 0;

        repeat (2) cycle(1, 0, 0, 0);
        // Hold exec long enough to start free-run, then let one instruction finish.
        repeat (6)  cycle(0, 1, 0, 0);
        repeat (14) cycle(0, 0, 0, 0);
        // Bouncing exec followed by a clean hold: one press only, stops the run.
        cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 0, 0, 0);
        repeat (4)  cycle(0, 1, 0, 0);
        repeat (20) cycle(0, 0, 0, 0);
        // Single step with a second step press during the instruction.
        repeat (5)  cycle(0, 0, 1, 0);
        repeat (5)  cycle(0, 0, 0, 0);
        repeat (5)  cycle(0, 0, 1, 0);
        repeat (10) cycle(0, 0, 0, 0);

        for (int k = 0; k < 4000; k++) begin
            if (eh == 0 && $urandom_range(0, 24) == 0) eh = $urandom_range(1, 7);
            if (sh == 0 && $urandom_range(0, 19) == 0) sh = $urandom_range(1, 7);
            e = (eh > 0); if (eh > 0) eh--;
            s = (sh > 0); if (sh > 0) sh--;
            if (m_mode == M_RUN || m_mode == M_STEP) h = ($urandom_range(0, 79) == 0);
            else                                     h = ($urandom_range(0, 299) == 0);
            halted_for = (m_mode == M_HALT) ? halted_for + 1 : 0;
            r = (halted_for > 25) || ($urandom_range(0, 399) == 0);
`ifdef PHASESEQ_LIMIT_EN
            if ($urandom_range(0, 149) == 0)
                instr_limit = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'(m_count + $urandom_range(1, 3));
`endif
            cycle(r, e, s, h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
